muldiv_sched: RTL and testbench

Sequencer and owner of the HI/LO register pair for MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO. It takes requests from the Execute stage and runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, then applies a sign-fixup cycle. It stalls the pipeline when a younger instruction needs HI/LO, or issues another request, while an operation is in flight. Execute's ALU never handles these opcodes; this block shares nothing combinationally with it.

---
 rtl/muldiv_sched.sv | 159 +++++++++++++++
 tb/tb_muldiv_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO: 32-step shift-add multiply
// or restoring divide on operand magnitudes, followed by one sign-fixup/write cycle.
module muldiv_sched (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        mf_req,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] orig_a_q, orig_a_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        is_div_q, is_div_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [31:0] div_sub;
  logic        div_ge;
  logic [63:0] prod_fix;

  assign signed_op = (req_op == 3'd0) || (req_op == 3'd2);
  assign abs_a     = req_a[31] ? 32'd0 - req_a : req_a;
  assign abs_b     = req_b[31] ? 32'd0 - req_b : req_b;
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  // Remainder after the left shift; it is below 2*divisor so 33 bits suffice.
  assign rem_sh    = acc_q[63:31];
  assign div_ge    = rem_sh >= {1'b0, opb_q};
  assign div_sub   = rem_sh[31:0] - opb_q;
  assign prod_fix  = neg_quo_q ? 64'd0 - acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    orig_a_d  = orig_a_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          case (req_op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              acc_d     = {32'd0, signed_op ? abs_a : req_a};
              opb_d     = signed_op ? abs_b : req_b;
              neg_quo_d = signed_op & (req_a[31] ^ req_b[31]);
              neg_rem_d = signed_op & req_a[31];
              orig_a_d  = req_a;
              dz_d      = (req_b == 32'd0);
              is_div_d  = req_op[1];
              cnt_d     = 5'd0;
              state_d   = req_op[1] ? StDiv : StMul;
            end
            3'd4:    hi_d = req_a;
            3'd5:    lo_d = req_a;
            default: ;
          endcase
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end
      StDiv: begin
        acc_d = {div_ge ? div_sub : rem_sh[31:0], acc_q[30:0], div_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end
      StFix: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (dz_q) begin
          hi_d = orig_a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = neg_rem_q ? 32'd0 - acc_q[63:32] : acc_q[63:32];
          lo_d = neg_quo_q ? 32'd0 - acc_q[31:0] : acc_q[31:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush beats everything in flight, including the FIX write.
    if (flush && state_q != StIdle) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      orig_a_q  <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      orig_a_q  <= orig_a_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != StIdle);
  assign stall = busy & (req_valid | mf_req);
  assign done  = done_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: expected {hi,lo} pushed at issue, popped on done.
module tb_muldiv_sched;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        mf_req;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  muldiv_sched dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .mf_req    (mf_req),
    .flush     (flush),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from language arithmetic on 64-bit values.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, qv, rv, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == 3'd0) begin
      p = sa * sb;
      return p;
    end
    if (op == 3'd1) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 3'd2) begin
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
    end else begin
      qv = ua / ub;
      rv = ua % ub;
    end
    return {rv[31:0], qv[31:0]};
  endfunction

  // Drives one request through its accepting edge and records the expected result.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv);
    exp_q.push_back(expv);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for done; reports how many busy cycles were sampled on the way.
  task automatic wait_done(output int cycles, output bit timeout);
    int n = 0;
    cycles = 0;
    while (!done && n < 100) begin
      if (busy) cycles++;
      n++;
      @(posedge clk);
      #1;
    end
    timeout = !done;
  endtask

  task automatic test_reset;
    resetn    = 1'b0;
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    mf_req    = 1'b1;
    flush     = 1'b0;
    #12;
    n_cmp++;
    if ({hi, lo, busy, done, stall} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b stall=%b, want all 0",
               hi, lo, busy, done, stall);
    end
    req_valid = 1'b0;
    mf_req    = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_and_check(input string name);
    int          cyc;
    bit          to;
    logic [63:0] e;
    wait_done(cyc, to);
    n_cmp++;
    if (to || cyc != 33) begin
      n_bad++;
      $display("FAIL %s_busy: got %0d busy cycles (timeout=%0b), want 33", name, cyc, to);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({hi, lo} !== e || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_result: got hi=%h lo=%h busy=%b, want hi=%h lo=%h busy=0",
               name, hi, lo, busy, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_mul;
    start_op(3'd1, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
    run_and_check("multu");
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse_width: got done=%b one cycle later, want 0", done);
    end
    start_op(3'd0, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_and_check("mult");
  endtask

  task automatic test_div;
    start_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_and_check("div_neg");
    start_op(3'd3, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC);
    run_and_check("divu");
  endtask

  task automatic test_div_edge;
    start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_and_check("div_ovf");
    start_op(3'd3, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF);
    run_and_check("divu_zero");
    start_op(3'd2, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);
    run_and_check("div_zero_neg");
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 3) ? 32'd0 : $urandom;
      if (i == 5) b = {28'd0, b[3:0]};
      start_op(op, a, b, model(op, a, b));
      run_and_check("random");
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int stall_bad = 0;
    logic [63:0] e;
    start_op(3'd0, 32'd3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4);
    exp_q.push_back(64'd35);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 32'd5;
    req_b     = 32'd7;
    mf_req    = 1'b1;
    while (!done && n < 100) begin
      if (stall !== 1'b1) stall_bad++;
      n++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (stall_bad != 0 || n != 33) begin
      n_bad++;
      $display("FAIL stall_window: got %0d stalled-low cycles over %0d busy, want 0 over 33",
               stall_bad, n);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_done_cycle: got stall=%b, want 0", stall);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({hi, lo} !== e) begin
      n_bad++;
      $display("FAIL b2b_first: got %h, want %h", {hi, lo}, e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mf_req    = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    run_and_check("b2b_second");
  endtask

  task automatic test_flush;
    int done_seen = 0;
    start_op(3'd4, 32'h11, 32'd0, 64'd0);
    void'(exp_q.pop_back());
    n_cmp++;
    if (hi !== 32'h11) begin
      n_bad++;
      $display("FAIL mthi: got hi=%h, want 00000011", hi);
    end
    start_op(3'd5, 32'h22, 32'd0, 64'd0);
    void'(exp_q.pop_back());
    n_cmp++;
    if (lo !== 32'h22) begin
      n_bad++;
      $display("FAIL mtlo: got lo=%h, want 00000022", lo);
    end
    start_op(3'd2, 32'd100, 32'd7, 64'd0);
    void'(exp_q.pop_back());
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle: got busy=%b, want 0", busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (done_seen != 0 || hi !== 32'h11 || lo !== 32'h22) begin
      n_bad++;
      $display("FAIL flush_hold: got done count %0d hi=%h lo=%h, want 0 11 22",
               done_seen, hi, lo);
    end
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = 32'h99;
    @(posedge clk);
    #1;
    req_op = 3'd1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    n_cmp++;
    if (hi !== 32'h11 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_req: got hi=%h busy=%b, want 00000011 0", hi, busy);
    end
    // Invalid opcode while idle must leave everything alone.
    req_valid = 1'b1;
    req_op    = 3'd6;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_cmp++;
    if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL invalid_op: got hi=%h lo=%h busy=%b, want 11 22 0", hi, lo, busy);
    end
  endtask

  task automatic test_reset_mid;
    start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
    void'(exp_q.pop_back());
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b, want all 0",
               hi, lo, busy, done);
    end
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    start_op(3'd5, 32'h0000_ABCD, 32'd0, 64'd0);
    void'(exp_q.pop_back());
    n_cmp++;
    if (lo !== 32'h0000_ABCD || hi !== 32'd0) begin
      n_bad++;
      $display("FAIL mtlo_after_reset: got hi=%h lo=%h, want 00000000 0000abcd", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_edge();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
